telemetry_uart_tx: RTL

Serial telemetry transmitter that takes the 8-bit samples produced by the data collector stage and sends them off-chip to a host as framed UART packets. It sits downstream of the power converter / data collector chain. It buffers samples in a small FIFO and serializes each one as a 3-byte packet: header, sample, checksum. It is the transmitting end of the host telemetry link; the host-side receiver decodes these packets.

---
 rtl/telemetry_uart_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/telemetry_uart_tx.sv
// Telemetry UART transmitter: buffers 8-bit samples in a small FIFO and sends
// each one as an 8N1 packet of three bytes: HEADER, sample, HEADER ^ sample.
module telemetry_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      hold_q, hold_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic            ovf_q, ovf_d;
  logic            full, empty, push, pop, baud_done;
  logic [7:0]      cur_byte;

  function automatic logic [7:0] packet_byte(input logic [1:0] idx, input logic [7:0] s);
    case (idx)
      2'd0:    return HEADER;
      2'd1:    return s;
      default: return HEADER ^ s;
    endcase
  endfunction

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push         = sample_valid && !full;
  assign pop          = (state_q == IDLE) && !empty;
  assign baud_done    = (baud_q == '0);
  assign cur_byte     = packet_byte(byte_idx_q, hold_q);

  assign sample_ready = !full;
  assign busy         = (state_q != IDLE);
  assign overflow     = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? (AW+1)'(1) : '0);
    rd_ptr_d = rd_ptr_q + (pop  ? (AW+1)'(1) : '0);
    hold_d   = pop ? mem_q[rd_ptr_q[AW-1:0]] : hold_q;
    ovf_d    = ovf_q | (sample_valid & full);
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    tx         = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d    = START;
          baud_d     = BAUD_RELOAD;
          byte_idx_d = 2'd0;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          baud_d    = BAUD_RELOAD;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      DATA: begin
        tx = cur_byte[bit_idx_q];
        if (baud_done) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          if (byte_idx_q == 2'd2) begin
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
            baud_d     = BAUD_RELOAD;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      ovf_q      <= ovf_d;
    end
  end

  // Sample storage carries no reset; validity is tracked by the pointers and FSM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= sample_in;
    hold_q <= hold_d;
  end

endmodule
